reorder_buffer: RTL and testbench

- Circular reorder buffer that tracks in-flight renamed instructions in program order.
- Captures functional-unit results from the common data bus (CDB) and retires at most one completed instruction per cycle from the head.
- Supplies the issue queue with the ROB tail index and with operand state for two source tags (contains / ready / data).
- Sits between rename/dispatch, the CDB and the architectural register file (ARF).

---
 rtl/reorder_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tracks renamed instructions in program order, captures
// CDB results, retires one completed instruction per cycle and answers operand lookups.
module reorder_buffer #(
  parameter int ROB_SIZE      = 64,
  parameter int ROB_SIZE_LOG2 = $clog2(ROB_SIZE),
  parameter int REG_SIZE      = 32,
  parameter int NUM_TAGS      = 64,
  parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
  parameter int ISSUE_PORTS   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [NUM_TAGS_LOG2-1:0] alloc_tag_rd,
  input  logic [4:0]               alloc_arch_rd,
  output logic [ROB_SIZE_LOG2-1:0] rob_tail,
  output logic                     rob_full,
  input  logic [NUM_TAGS_LOG2-1:0] lookup_tag_rs [2],
  output logic [REG_SIZE-1:0]      rob_data_rs [2],
  output logic [1:0]               rob_contains_rs,
  output logic [1:0]               rob_ready_rs,
  input  logic [NUM_TAGS_LOG2-1:0] cdb_tags [ISSUE_PORTS],
  input  logic [REG_SIZE-1:0]      cdb_data [ISSUE_PORTS],
  input  logic [ISSUE_PORTS-1:0]   cdb_valid,
  output logic                     retire_valid,
  output logic [4:0]               retire_arch_rd,
  output logic [NUM_TAGS_LOG2-1:0] retire_tag,
  output logic [REG_SIZE-1:0]      retire_data
);

  localparam int CNT_W = ROB_SIZE_LOG2 + 1;

  logic [ROB_SIZE_LOG2-1:0] head_reg;
  logic [ROB_SIZE_LOG2-1:0] tail_reg;
  logic [CNT_W-1:0]         count_reg;

  logic                     ent_valid [ROB_SIZE];
  logic                     ent_done  [ROB_SIZE];
  logic [NUM_TAGS_LOG2-1:0] ent_tag   [ROB_SIZE];
  logic [4:0]               ent_arch  [ROB_SIZE];
  logic [REG_SIZE-1:0]      ent_data  [ROB_SIZE];

  logic                alloc_fire;
  logic                retire_fire;
  logic                alloc_hit;
  logic                alloc_done;
  logic [REG_SIZE-1:0] alloc_data;

  assign rob_full    = (count_reg == CNT_W'(ROB_SIZE));
  assign rob_tail    = tail_reg;
  assign alloc_fire  = alloc_valid && !rob_full;
  assign retire_fire = ent_valid[head_reg] && ent_done[head_reg];

  // A new entry may already see its result on the CDB in the cycle it is allocated.
  always_comb begin
    alloc_hit  = 1'b0;
    alloc_data = '0;
    for (int l = 0; l < ISSUE_PORTS; l++) begin
      if (cdb_valid[l] && cdb_tags[l] == alloc_tag_rd && alloc_tag_rd != '0) begin
        alloc_hit  = 1'b1;
        alloc_data = cdb_data[l];
      end
    end
  end

  assign alloc_done = (alloc_tag_rd == '0) || alloc_hit;

  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      logic                     valid_reg;
      logic                     done_reg;
      logic [NUM_TAGS_LOG2-1:0] tag_reg;
      logic [4:0]               arch_reg;
      logic [REG_SIZE-1:0]      data_reg;
      logic                     cdb_hit;
      logic [REG_SIZE-1:0]      cdb_val;
      logic                     is_head;
      logic                     is_tail;

      assign is_head = (head_reg == ROB_SIZE_LOG2'(gi));
      assign is_tail = (tail_reg == ROB_SIZE_LOG2'(gi));

      // Later lanes override earlier ones so the highest matching lane wins.
      always_comb begin
        cdb_hit = 1'b0;
        cdb_val = '0;
        for (int l = 0; l < ISSUE_PORTS; l++) begin
          if (cdb_valid[l] && cdb_tags[l] == tag_reg && tag_reg != '0) begin
            cdb_hit = 1'b1;
            cdb_val = cdb_data[l];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (retire_fire && is_head) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (alloc_fire && is_tail) begin
          valid_reg <= 1'b1;
          done_reg  <= alloc_done;
          tag_reg   <= alloc_tag_rd;
          arch_reg  <= alloc_arch_rd;
          data_reg  <= alloc_data;
        end else if (valid_reg && cdb_hit) begin
          done_reg <= 1'b1;
          data_reg <= cdb_val;
        end
      end

      assign ent_valid[gi] = valid_reg;
      assign ent_done[gi]  = done_reg;
      assign ent_tag[gi]   = tag_reg;
      assign ent_arch[gi]  = arch_reg;
      assign ent_data[gi]  = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      retire_valid   <= 1'b0;
      retire_arch_rd <= '0;
      retire_tag     <= '0;
      retire_data    <= '0;
    end else begin
      if (alloc_fire) tail_reg <= tail_reg + 1'b1;
      if (retire_fire) head_reg <= head_reg + 1'b1;
      case ({alloc_fire, retire_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      retire_valid <= retire_fire;
      if (retire_fire) begin
        retire_arch_rd <= ent_arch[head_reg];
        retire_tag     <= ent_tag[head_reg];
        retire_data    <= ent_data[head_reg];
      end
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      logic                     hit;
      logic [ROB_SIZE_LOG2-1:0] sel;
      logic [ROB_SIZE_LOG2-1:0] idx;
      logic                     byp_hit;
      logic [REG_SIZE-1:0]      byp_val;
      logic                     contains;
      logic                     ready;
      logic [REG_SIZE-1:0]      data;

      // Walk from oldest to youngest so the last match is the one nearest the tail.
      always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = 0; k < ROB_SIZE; k++) begin
          idx = head_reg + ROB_SIZE_LOG2'(k);
          if (ent_valid[idx] && ent_tag[idx] == lookup_tag_rs[gi]) begin
            hit = 1'b1;
            sel = idx;
          end
        end
      end

      always_comb begin
        byp_hit = 1'b0;
        byp_val = '0;
        for (int l = 0; l < ISSUE_PORTS; l++) begin
          if (cdb_valid[l] && cdb_tags[l] == lookup_tag_rs[gi]) begin
            byp_hit = 1'b1;
            byp_val = cdb_data[l];
          end
        end
      end

      // A miss means the value lives in the ARF, so it is reported ready with no data.
      always_comb begin
        contains = 1'b0;
        ready    = 1'b1;
        data     = '0;
        if (lookup_tag_rs[gi] != '0 && hit) begin
          contains = 1'b1;
          if (ent_done[sel]) begin
            data = ent_data[sel];
          end else if (byp_hit) begin
            data = byp_val;
          end else begin
            ready = 1'b0;
          end
        end
      end

      assign rob_contains_rs[gi] = contains;
      assign rob_ready_rs[gi]    = ready;
      assign rob_data_rs[gi]     = data;
    end
  endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based program-order model.
module tb_reorder_buffer;
  localparam int RS = 64;
  localparam int NP = 3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic [5:0]  alloc_tag_rd;
  logic [4:0]  alloc_arch_rd;
  logic [5:0]  rob_tail;
  logic        rob_full;
  logic [5:0]  lookup_tag_rs [2];
  logic [31:0] rob_data_rs [2];
  logic [1:0]  rob_contains_rs;
  logic [1:0]  rob_ready_rs;
  logic [5:0]  cdb_tags [NP];
  logic [31:0] cdb_data [NP];
  logic [2:0]  cdb_valid;
  logic        retire_valid;
  logic [4:0]  retire_arch_rd;
  logic [5:0]  retire_tag;
  logic [31:0] retire_data;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_tag_rd(alloc_tag_rd), .alloc_arch_rd(alloc_arch_rd),
    .rob_tail(rob_tail), .rob_full(rob_full),
    .lookup_tag_rs(lookup_tag_rs), .rob_data_rs(rob_data_rs),
    .rob_contains_rs(rob_contains_rs), .rob_ready_rs(rob_ready_rs),
    .cdb_tags(cdb_tags), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .retire_valid(retire_valid), .retire_arch_rd(retire_arch_rd),
    .retire_tag(retire_tag), .retire_data(retire_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  arch;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          head_m = 0;
  logic        m_ret_valid = 1'b0;
  logic [4:0]  m_ret_arch = '0;
  logic [5:0]  m_ret_tag = '0;
  logic [31:0] m_ret_data = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic void m_lookup(input logic [5:0] t, output logic c, output logic r,
                                   output logic [31:0] d);
    c = 1'b0; r = 1'b1; d = '0;
    if (t == 6'd0) return;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].tag == t) begin
        c = 1'b1;
        if (q[k].done) d = q[k].data;
        else begin
          r = 1'b0;
          for (int l = 0; l < NP; l++)
            if (cdb_valid[l] && cdb_tags[l] == t) begin r = 1'b1; d = cdb_data[l]; end
        end
        return;
      end
    end
  endfunction

  task automatic model_step();
    bit   do_ret;
    bit   do_alloc;
    ent_t e;
    if (!rst || flush) begin
      q.delete();
      head_m = 0;
      m_ret_valid = 1'b0; m_ret_arch = '0; m_ret_tag = '0; m_ret_data = '0;
      return;
    end
    do_ret   = (q.size() > 0) && q[0].done;
    do_alloc = alloc_valid && (q.size() < RS);
    m_ret_valid = do_ret;
    if (do_ret) begin
      m_ret_arch = q[0].arch; m_ret_tag = q[0].tag; m_ret_data = q[0].data;
    end
    for (int k = 0; k < q.size(); k++) begin
      e = q[k];
      for (int l = 0; l < NP; l++)
        if (cdb_valid[l] && cdb_tags[l] == e.tag && e.tag != 6'd0) begin
          e.done = 1'b1; e.data = cdb_data[l];
        end
      q[k] = e;
    end
    if (do_ret) begin
      void'(q.pop_front());
      head_m = (head_m + 1) % RS;
    end
    if (do_alloc) begin
      e.tag = alloc_tag_rd; e.arch = alloc_arch_rd;
      e.done = (alloc_tag_rd == 6'd0); e.data = '0;
      for (int l = 0; l < NP; l++)
        if (cdb_valid[l] && cdb_tags[l] == alloc_tag_rd && alloc_tag_rd != 6'd0) begin
          e.done = 1'b1; e.data = cdb_data[l];
        end
      q.push_back(e);
    end
  endtask

  // One clock cycle: combinational checks with current inputs, edge, registered checks.
  task automatic tick();
    logic        c, r;
    logic [31:0] d;
    #1;
    check("rob_tail", 32'(rob_tail), 32'((head_m + q.size()) % RS));
    check("rob_full", 32'(rob_full), 32'(q.size() == RS));
    for (int j = 0; j < 2; j++) begin
      m_lookup(lookup_tag_rs[j], c, r, d);
      check($sformatf("contains%0d tag%0d", j, lookup_tag_rs[j]), 32'(rob_contains_rs[j]), 32'(c));
      check($sformatf("ready%0d tag%0d", j, lookup_tag_rs[j]), 32'(rob_ready_rs[j]), 32'(r));
      check($sformatf("data%0d tag%0d", j, lookup_tag_rs[j]), rob_data_rs[j], d);
    end
    model_step();
    @(posedge clk);
    #1;
    check("retire_valid", 32'(retire_valid), 32'(m_ret_valid));
    check("retire_arch_rd", 32'(retire_arch_rd), 32'(m_ret_arch));
    check("retire_tag", 32'(retire_tag), 32'(m_ret_tag));
    check("retire_data", retire_data, m_ret_data);
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    flush = 1'b0;
    cdb_valid = '0;
  endtask

  task automatic do_alloc(input logic [5:0] t, input logic [4:0] a);
    alloc_valid = 1'b1; alloc_tag_rd = t; alloc_arch_rd = a;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic set_cdb(input int lane, input logic [5:0] t, input logic [31:0] d);
    cdb_valid = '0;
    cdb_valid[lane] = 1'b1;
    cdb_tags[lane] = t;
    cdb_data[lane] = d;
  endtask

  function automatic logic [5:0] wrap_tag(input int i);
    return (i == 2) ? 6'd9 : 6'(10 + (i % 40));
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_tag_rd = '0; alloc_arch_rd = '0;
    lookup_tag_rs[0] = '0; lookup_tag_rs[1] = '0; cdb_valid = '0;
    for (int l = 0; l < NP; l++) begin cdb_tags[l] = '0; cdb_data[l] = '0; end
    repeat (2) @(posedge clk);
    #1;
    tick();
    check("reset retire_valid", 32'(retire_valid), 32'd0);
    check("reset rob_tail", 32'(rob_tail), 32'd0);
    rst = 1'b1;

    do_alloc(6'd5, 5'd1);
    do_alloc(6'd6, 5'd2);
    do_alloc(6'd7, 5'd3);
    lookup_tag_rs[0] = 6'd6;
    #1;
    check("tail after 3 allocs", 32'(rob_tail), 32'd3);
    check("not full after 3", 32'(rob_full), 32'd0);
    check("lookup6 contains", 32'(rob_contains_rs[0]), 32'd1);
    check("lookup6 not ready", 32'(rob_ready_rs[0]), 32'd0);

    set_cdb(2, 6'd6, 32'hDEADBEEF);
    #1;
    check("lookup6 bypass ready", 32'(rob_ready_rs[0]), 32'd1);
    check("lookup6 bypass data", rob_data_rs[0], 32'hDEADBEEF);
    tick();
    check("no retire before tag5", 32'(retire_valid), 32'd0);
    set_cdb(0, 6'd5, 32'h11);
    tick();
    check("no retire same edge as done", 32'(retire_valid), 32'd0);
    idle_inputs();
    tick();
    check("retire tag5 valid", 32'(retire_valid), 32'd1);
    check("retire tag5 arch", 32'(retire_arch_rd), 32'd1);
    check("retire tag5 data", retire_data, 32'h11);
    tick();
    check("retire tag6 data", retire_data, 32'hDEADBEEF);

    lookup_tag_rs[0] = 6'd0; lookup_tag_rs[1] = 6'd40;
    #1;
    check("lookup0 contains", 32'(rob_contains_rs[0]), 32'd0);
    check("lookup0 ready", 32'(rob_ready_rs[0]), 32'd1);
    check("lookup40 contains", 32'(rob_contains_rs[1]), 32'd0);
    check("lookup40 ready", 32'(rob_ready_rs[1]), 32'd1);
    tick();

    // Fill to capacity, overflow attempt, then retire and refill across the wrap.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < RS; i++) do_alloc(6'(20 + (i % 40)), 5'(i % 32));
    check("full after 64", 32'(rob_full), 32'd1);
    check("tail wrapped to 0", 32'(rob_tail), 32'd0);
    do_alloc(6'd3, 5'd3);
    check("65th alloc ignored", 32'(rob_tail), 32'd0);
    alloc_valid = 1'b1; alloc_tag_rd = 6'd3;
    set_cdb(1, 6'd20, 32'hA5A5);
    tick();
    cdb_valid = '0;
    tick();
    check("head retired while full", 32'(retire_valid), 32'd1);
    check("not full after retire", 32'(rob_full), 32'd0);
    tick();
    alloc_valid = 1'b0;
    check("tail after refill", 32'(rob_tail), 32'd1);
    check("full after refill", 32'(rob_full), 32'd1);

    // Tag 9 lives at index 2, retires, and is reused at index 62.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 62; i++) do_alloc(wrap_tag(i), 5'(i % 32));
    for (int i = 0; i < 62; i++) begin
      set_cdb(i % 3, wrap_tag(i), 32'h100 + 32'(i));
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("tail before reuse", 32'(rob_tail), 32'd62);
    do_alloc(6'd9, 5'd7);
    lookup_tag_rs[0] = 6'd9;
    #1;
    check("reuse tag9 contains", 32'(rob_contains_rs[0]), 32'd1);
    check("reuse tag9 not ready", 32'(rob_ready_rs[0]), 32'd0);
    set_cdb(0, 6'd9, 32'h1234);
    tick();
    idle_inputs();
    #1;
    check("reuse tag9 ready", 32'(rob_ready_rs[0]), 32'd1);
    check("reuse tag9 data", rob_data_rs[0], 32'h1234);
    tick();

    // Reset and flush with live entries and a pending retire.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) do_alloc(6'(30 + i), 5'(i));
      set_cdb(0, 6'd30, 32'h77);
      tick();
      idle_inputs();
      lookup_tag_rs[0] = 6'd31;
      if (pass == 0) rst = 1'b0; else flush = 1'b1;
      tick();
      rst = 1'b1; flush = 1'b0;
      check("clear retire_valid", 32'(retire_valid), 32'd0);
      check("clear rob_tail", 32'(rob_tail), 32'd0);
      check("clear rob_full", 32'(rob_full), 32'd0);
      check("clear lookup31", 32'(rob_contains_rs[0]), 32'd0);
    end

    // Random traffic: an early low-completion phase drives the buffer toward full.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int cdb_odds;
      cdb_odds = (cyc < 400) ? 12 : 3;
      alloc_valid   = ($urandom_range(0, 3) != 0);
      alloc_tag_rd  = 6'($urandom_range(0, 15));
      alloc_arch_rd = 5'($urandom_range(0, 31));
      for (int l = 0; l < NP; l++) begin
        cdb_valid[l] = ($urandom_range(0, cdb_odds - 1) == 0);
        cdb_tags[l]  = 6'($urandom_range(0, 15));
        cdb_data[l]  = $urandom;
      end
      for (int j = 0; j < 2; j++)
        lookup_tag_rs[j] = ($urandom_range(0, 7) == 0) ? 6'd40 : 6'($urandom_range(0, 15));
      flush = ($urandom_range(0, 299) == 0);
      rst   = !($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b1;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
